// File: rtl/sr2dr_bridge_if.sv
// sr2dr_bridge_if
//   Bundles the single-rail input handshake and the dual-rail output bus of
//   sr2dr_bridge.
//   master : the bridge's view (accepts words, drives rails, reads acks)
//   slave  : the environment's view (feeds words, watches rails, drives acks)
// Signals:
//   in_valid / in_ready / in_data : single-rail word handshake
//   out_t / out_f                 : true / false rails, one pair per bit
//   out_ack                       : per-bit completion from downstream latches
//   busy / err                    : activity indicator, sticky timeout flag
interface sr2dr_bridge_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [W-1:0] out_t;
  logic [W-1:0] out_f;
  logic [W-1:0] out_ack;
  logic         busy;
  logic         err;

  modport master (
    input  in_valid, in_data, out_ack,
    output in_ready, out_t, out_f, busy, err
  );

  modport slave (
    output in_valid, in_data, out_ack,
    input  in_ready, out_t, out_f, busy, err
  );
endinterface

// File: rtl/sr2dr_bridge.sv
// sr2dr_bridge
//   Accepts single-rail words over valid/ready, buffers them in a small FIFO
//   and drives each onto a W-bit dual-rail bus with the 4-phase protocol:
//   data wave -> wait all acks high -> spacer -> wait all acks low.
//   A sticky err flag reports a downstream stage that stalls for TIMEOUT
//   cycles in DATA or SPACER; the FSM keeps waiting regardless.
// Parameters:
//   W       : bus width (1..64)
//   DEPTH   : FIFO depth, power of 2, >= 2
//   SYNC    : 0 or 2 synchronizer flops on out_ack
//   TIMEOUT : wait-cycle limit before err sets, 0 disables
// Ports:
//   ck    : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : sr2dr_bridge_if.master (handshake, rails, acks, busy, err)
module sr2dr_bridge #(
  parameter int W       = 8,
  parameter int DEPTH   = 2,
  parameter int SYNC    = 0,
  parameter int TIMEOUT = 1024
) (
  input  logic                ck,
  input  logic                reset,
  sr2dr_bridge_if.master      bus
);

  localparam int AW = $clog2(DEPTH);
  // $clog2(1) is 0, so a disabled timeout still needs a 1-bit counter.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [AW:0]   FULL_C = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] TMAX   = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    SPACER = 2'd2
  } state_t;

  state_t          state_reg;
  logic [W-1:0]    mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic [W-1:0]    t_reg;
  logic [W-1:0]    f_reg;
  logic [CW-1:0]   tcnt_reg;
  logic [CW-1:0]   tcnt_plus;
  logic            err_reg;

  logic [W-1:0]    ack;
  logic            all_hi;
  logic            all_lo;
  logic            empty;
  logic            push;
  logic            pop;
  logic [W-1:0]    head;

  // Ack synchronizer: with SYNC=2 the FSM sees out_ack two edges late.
  generate
    if (SYNC == 2) begin : g_sync
      logic [W-1:0] s1_reg;
      logic [W-1:0] s2_reg;
      always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
          s1_reg <= '0;
          s2_reg <= '0;
        end else begin
          s1_reg <= bus.out_ack;
          s2_reg <= s1_reg;
        end
      end
      assign ack = s2_reg;
    end else begin : g_nosync
      assign ack = bus.out_ack;
    end
  endgenerate

  // A mixed ack pattern is neither complete nor released.
  assign all_hi = &ack;
  assign all_lo = ~|ack;

  assign empty = (count_reg == '0);
  // Full blocks a push even when a pop happens on the same edge, which
  // keeps in_ready free of any path from the FSM's ack decode.
  assign push  = bus.in_valid && (count_reg != FULL_C);
  assign pop   = !empty && all_lo && ((state_reg == IDLE) || (state_reg == SPACER));
  assign head  = mem[rd_ptr_reg];

  // FIFO storage (no reset needed: count/pointers define validity).
  always_ff @(posedge ck) begin
    if (push) begin
      mem[wr_ptr_reg] <= bus.in_data;
    end
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign tcnt_plus = tcnt_reg + 1'b1;

  // Protocol FSM. Rails are only written on state transitions, and every
  // transition writes either a complementary pair or all zeros, so t&f is
  // never set on any bit.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      t_reg     <= '0;
      f_reg     <= '0;
      tcnt_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          tcnt_reg <= '0;
          if (pop) begin
            t_reg     <= head;
            f_reg     <= ~head;
            state_reg <= DATA;
          end
        end
        DATA: begin
          if (all_hi) begin
            t_reg     <= '0;
            f_reg     <= '0;
            tcnt_reg  <= '0;
            state_reg <= SPACER;
          end else begin
            if (tcnt_reg != TMAX) tcnt_reg <= tcnt_plus;
            if ((TIMEOUT != 0) && (tcnt_plus == TMAX)) err_reg <= 1'b1;
          end
        end
        SPACER: begin
          if (all_lo) begin
            tcnt_reg <= '0;
            if (pop) begin
              t_reg     <= head;
              f_reg     <= ~head;
              state_reg <= DATA;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            if (tcnt_reg != TMAX) tcnt_reg <= tcnt_plus;
            if ((TIMEOUT != 0) && (tcnt_plus == TMAX)) err_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          t_reg     <= '0;
          f_reg     <= '0;
          tcnt_reg  <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready = (count_reg != FULL_C);
  assign bus.busy     = (state_reg != IDLE) || !empty;
  assign bus.err      = err_reg;
  assign bus.out_t    = t_reg;
  assign bus.out_f    = f_reg;

endmodule

// File: tb/tb_sr2dr_bridge.sv
// tb_sr2dr_bridge
//   Directed bench for sr2dr_bridge. dut0 runs with SYNC=0, dut2 with SYNC=2;
//   both W=8, DEPTH=2, TIMEOUT=16 and share clock and reset.
module tb_sr2dr_bridge;

  logic ck = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 ck = ~ck;

  sr2dr_bridge_if #(.W(8)) bus0 ();
  sr2dr_bridge_if #(.W(8)) bus2 ();

  sr2dr_bridge #(.W(8), .DEPTH(2), .SYNC(0), .TIMEOUT(16)) dut0 (
    .ck    (ck),
    .reset (reset),
    .bus   (bus0)
  );

  sr2dr_bridge #(.W(8), .DEPTH(2), .SYNC(2), .TIMEOUT(16)) dut2 (
    .ck    (ck),
    .reset (reset),
    .bus   (bus2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge ck);
    #1;
  endtask

  task automatic rails0(input string tag, input logic [7:0] t, input logic [7:0] f);
    chk({tag, ".t"}, {56'd0, bus0.out_t}, {56'd0, t});
    chk({tag, ".f"}, {56'd0, bus0.out_f}, {56'd0, f});
  endtask

  task automatic rails2(input string tag, input logic [7:0] t, input logic [7:0] f);
    chk({tag, ".t"}, {56'd0, bus2.out_t}, {56'd0, t});
    chk({tag, ".f"}, {56'd0, bus2.out_f}, {56'd0, f});
  endtask

  // Short reset pulse, issued 1 unit after an edge so it stays clear of edges.
  task automatic pulse_reset();
    reset = 1'b0;
    #3;
    reset = 1'b1;
  endtask

  initial begin
    reset         = 1'b0;
    bus0.in_valid = 1'b0;
    bus0.in_data  = 8'h00;
    bus0.out_ack  = 8'h00;
    bus2.in_valid = 1'b0;
    bus2.in_data  = 8'h00;
    bus2.out_ack  = 8'h00;
    #12;
    rails0("rst", 8'h00, 8'h00);
    chk("rst.in_ready", {63'd0, bus0.in_ready}, 64'd1);
    chk("rst.busy", {63'd0, bus0.busy}, 64'd0);
    chk("rst.err", {63'd0, bus0.err}, 64'd0);
    reset = 1'b1;
    step(1);

    // ---- Reset mid-DATA ----
    bus0.in_valid = 1'b1; bus0.in_data = 8'hA5;
    step(1);
    bus0.in_valid = 1'b0;
    step(1);
    rails0("middata.wave", 8'hA5, 8'h5A);
    chk("middata.busy", {63'd0, bus0.busy}, 64'd1);
    #1;
    reset = 1'b0;
    #1;
    rails0("middata.async", 8'h00, 8'h00);
    chk("middata.in_ready", {63'd0, bus0.in_ready}, 64'd1);
    chk("middata.busy0", {63'd0, bus0.busy}, 64'd0);
    chk("middata.err", {63'd0, bus0.err}, 64'd0);
    #1;
    reset = 1'b1;
    step(1);

    // ---- Single word, SYNC=0 ----
    bus0.in_valid = 1'b1; bus0.in_data = 8'h3C;
    step(1);                                   // edge 0: push
    bus0.in_valid = 1'b0;
    rails0("single.e0", 8'h00, 8'h00);
    step(1);                                   // edge 1
    rails0("single.e1", 8'h3C, 8'hC3);
    step(1);                                   // edge 2
    rails0("single.e2", 8'h3C, 8'hC3);
    bus0.out_ack = 8'hFF;
    step(1);                                   // edge 3
    rails0("single.e3", 8'h00, 8'h00);
    chk("single.e3.busy", {63'd0, bus0.busy}, 64'd1);
    step(1);                                   // edge 4
    bus0.out_ack = 8'h00;
    chk("single.e4.busy", {63'd0, bus0.busy}, 64'd1);
    step(1);                                   // edge 5
    chk("single.e5.busy", {63'd0, bus0.busy}, 64'd0);
    chk("single.e5.in_ready", {63'd0, bus0.in_ready}, 64'd1);

    // ---- Back-pressure, DEPTH=2 ----
    bus0.in_valid = 1'b1; bus0.in_data = 8'h01;
    step(1);
    bus0.in_data = 8'h02;
    step(1);
    rails0("bp.w1", 8'h01, 8'hFE);
    chk("bp.ready_after2", {63'd0, bus0.in_ready}, 64'd1);
    bus0.in_data = 8'h03;
    step(1);
    chk("bp.full", {63'd0, bus0.in_ready}, 64'd0);
    bus0.in_data = 8'h04;                      // offered while full: must be dropped
    step(1);
    chk("bp.full2", {63'd0, bus0.in_ready}, 64'd0);
    rails0("bp.hold", 8'h01, 8'hFE);
    step(1);
    rails0("bp.hold2", 8'h01, 8'hFE);
    bus0.out_ack = 8'hFF;
    step(1);
    rails0("bp.sp1", 8'h00, 8'h00);
    chk("bp.sp1.full", {63'd0, bus0.in_ready}, 64'd0);
    bus0.out_ack = 8'h00;
    step(1);                                   // pop with valid high while full
    rails0("bp.w2", 8'h02, 8'hFD);
    chk("bp.w2.ready", {63'd0, bus0.in_ready}, 64'd1);
    bus0.in_valid = 1'b0;
    bus0.out_ack = 8'hFF;
    step(1);
    rails0("bp.sp2", 8'h00, 8'h00);
    bus0.out_ack = 8'h00;
    step(1);
    rails0("bp.w3", 8'h03, 8'hFC);
    chk("bp.w3.busy", {63'd0, bus0.busy}, 64'd1);
    bus0.out_ack = 8'hFF;
    step(1);
    rails0("bp.sp3", 8'h00, 8'h00);
    bus0.out_ack = 8'h00;
    step(1);
    chk("bp.idle.busy", {63'd0, bus0.busy}, 64'd0);
    rails0("bp.idle", 8'h00, 8'h00);

    // ---- Mixed ack ----
    bus0.in_valid = 1'b1; bus0.in_data = 8'h5A;
    step(1);
    bus0.in_valid = 1'b0;
    step(1);
    rails0("mix.wave", 8'h5A, 8'hA5);
    bus0.out_ack = 8'h7F;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("mix.hold.t", {56'd0, bus0.out_t}, 64'h5A);
    end
    bus0.out_ack = 8'hFF;
    step(1);
    rails0("mix.spacer", 8'h00, 8'h00);
    bus0.out_ack = 8'h00;
    step(1);
    chk("mix.idle.busy", {63'd0, bus0.busy}, 64'd0);

    // ---- Timeout, TIMEOUT=16 ----
    pulse_reset();
    step(1);
    chk("to.err_cleared", {63'd0, bus0.err}, 64'd0);
    bus0.in_valid = 1'b1; bus0.in_data = 8'h96;
    step(1);
    bus0.in_valid = 1'b0;
    step(1);                                   // entered DATA on this edge
    rails0("to.wave", 8'h96, 8'h69);
    step(15);
    chk("to.err_at15", {63'd0, bus0.err}, 64'd0);
    step(1);
    chk("to.err_at16", {63'd0, bus0.err}, 64'd1);
    rails0("to.still", 8'h96, 8'h69);
    step(3);
    chk("to.err_sat", {63'd0, bus0.err}, 64'd1);
    bus0.out_ack = 8'hFF;
    step(1);
    rails0("to.spacer", 8'h00, 8'h00);
    chk("to.err_sticky1", {63'd0, bus0.err}, 64'd1);
    bus0.out_ack = 8'h00;
    step(1);
    chk("to.err_sticky2", {63'd0, bus0.err}, 64'd1);
    chk("to.idle.busy", {63'd0, bus0.busy}, 64'd0);

    // ---- SYNC=2, single word ----
    pulse_reset();
    step(1);
    chk("s2.rst.err", {63'd0, bus2.err}, 64'd0);
    bus2.in_valid = 1'b1; bus2.in_data = 8'h3C;
    step(1);                                   // edge 0: push
    bus2.in_valid = 1'b0;
    step(1);                                   // edge 1
    rails2("s2.e1", 8'h3C, 8'hC3);
    step(1);                                   // edge 2
    bus2.out_ack = 8'hFF;
    step(1);                                   // edge 3
    rails2("s2.e3", 8'h3C, 8'hC3);
    step(1);                                   // edge 4
    rails2("s2.e4", 8'h3C, 8'hC3);
    step(1);                                   // edge 5
    rails2("s2.e5", 8'h00, 8'h00);
    step(1);                                   // edge 6
    bus2.out_ack = 8'h00;
    step(1);                                   // edge 7
    chk("s2.e7.busy", {63'd0, bus2.busy}, 64'd1);
    step(1);                                   // edge 8
    chk("s2.e8.busy", {63'd0, bus2.busy}, 64'd1);
    step(1);                                   // edge 9
    chk("s2.e9.busy", {63'd0, bus2.busy}, 64'd0);
    rails2("s2.e9", 8'h00, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
